rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: instruction fetch (read-only) and the load/store unit (loads and stores).
- Sits between the fetch stage / LSU and the memory.
- One transaction is outstanding at a time, so responses always return in order.
- LSU has fixed priority, with a streak limit so fetch cannot starve; a response timeout keeps a silent memory from hanging the core.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- MAX_LSU_STREAK, 4, maximum consecutive LSU grants while fetch is pending.
- TIMEOUT, 255, WAIT-state cycles before an error response is returned; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: fetch response.
- if_rdata  out  DW  fetch read data.
- if_err  out  1  qualifies if_rvalid: the transaction timed out.
- lsu_req  in  1  LSU request; held with its payload until lsu_gnt.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_addr  in  AW  LSU address.
- lsu_wdata  in  DW  store data.
- lsu_be  in  DW/8  byte enables.
- lsu_gnt  out  1  one-cycle pulse: LSU request accepted.
- lsu_rvalid  out  1  one-cycle pulse: LSU response (a store also gets one).
- lsu_rdata  out  DW  load data.
- lsu_err  out  1  qualifies lsu_rvalid: the transaction timed out.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  DW/8  memory byte enables.
- mem_ready  in  1  memory accepts the request in the cycle mem_req && mem_ready.
- mem_rvalid  in  1  memory response, one cycle.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset:
  - state = IDLE; owner, streak and timeout counters = 0.
  - All outputs are 0, including rdata and the mem_* payload registers.
  - Reset mid-transaction abandons it: no rvalid is produced for it, and a later mem_rvalid is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Arbitrates when either req is high.
  - Grant order: LSU, unless the streak equals MAX_LSU_STREAK and if_req is high, in which case fetch wins.
  - In the grant cycle: pulse the winner's gnt, latch its payload into the mem_* registers (fetch: we=0, be=all ones, wdata=0), record owner, go to ISSUE.
- ISSUE:
  - mem_req=1 with the latched payload, which is stable until accepted.
  - On mem_ready: go to WAIT and clear the timeout counter.
- WAIT:
  - mem_req=0; the counter increments each cycle.
  - On mem_rvalid: pulse the owner's rvalid for one cycle, with rdata=mem_rdata registered (one cycle after mem_rvalid) and err=0; return to IDLE.
  - If the counter reaches TIMEOUT first: pulse the owner's rvalid with err=1 and rdata=0; return to IDLE.
  - A mem_rvalid arriving in the same cycle the timeout fires takes precedence, giving a normal response.
- Latency:
  - Request to gnt: same cycle when IDLE.
  - Grant to mem_req: 1 cycle.
  - mem_rvalid to requester rvalid: 1 cycle.
  - Minimum gnt-to-gnt spacing for back-to-back transactions is 4 cycles with zero-wait memory.
- Streak counter:
  - Increments on an LSU grant while if_req is high.
  - Clears on any fetch grant, and on an LSU grant while if_req is low.
  - Saturates at MAX_LSU_STREAK.
- Ignored inputs:
  - mem_rvalid in IDLE or ISSUE is ignored.
  - A req deasserted before gnt is a protocol violation: no grant is owed and the outputs are unaffected.
- rdata on the non-owner port holds its previous value; rvalid is the only qualifier.

Decomposition:
- Package rv_mem_pkg holds:
  - the arb_state_e enum (IDLE/ISSUE/WAIT);
  - the owner_e enum (OWN_IF/OWN_LSU);
  - a mem_req_t struct {we, addr, wdata, be} shared by the LSU and the arbiter.
- One sub-module, rv_mem_arb_pick: combinational priority/streak selection taking both reqs and the streak, returning winner and grant_valid, so it can be checked in isolation.

Test Plan:
- Fetch only:
  - if_req, addr 0x100; memory returns 0xDEADBEEF with mem_ready=1 at ISSUE and mem_rvalid 2 cycles later.
  - Expect: if_gnt at cycle 0, mem_req at cycle 1 with we=0 and be=0xF, if_rvalid with rdata 0xDEADBEEF exactly once, lsu_rvalid never.
- Simultaneous requests:
  - if_req and lsu_req (store, addr 0x200, wdata 0x12345678, be 0x3) in the same cycle.
  - Expect: lsu_gnt first and mem_we=1 with the payload; fetch granted after the LSU rvalid.
- Starvation guard:
  - lsu_req and if_req held continuously.
  - Expect: grant sequence LSU×4, IF, LSU×4, IF.
- Memory stall:
  - mem_ready low for 5 cycles in ISSUE.
  - Expect: mem_req and payload stable all 5 cycles, a single acceptance, no duplicate request.
- Timeout:
  - TIMEOUT=8 and mem_rvalid never arrives.
  - Expect: lsu_rvalid=1, lsu_err=1, lsu_rdata=0 eight cycles after acceptance; state returns to IDLE and the next fetch completes normally.
- Reset mid-WAIT:
  - Assert rst in WAIT, then a late mem_rvalid arrives after reset.
  - Expect: all outputs 0, no rvalid on either port, next request served normally.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types for the unified-memory arbiter and the load/store unit.
package rv_mem_pkg;

  // Payload widths carried by mem_req_t; the arbiter's AW/DW must match these.
  localparam int unsigned MEM_AW = 32;
  localparam int unsigned MEM_DW = 32;
  localparam int unsigned MEM_BW = MEM_DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
    logic [MEM_BW-1:0] be;
  } mem_req_t;

  // Bits needed to hold a counter value 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rv_mem_arb_pick.sv
// Priority pick between fetch and LSU: LSU wins unless it has used up its
// streak while fetch is waiting.
module rv_mem_arb_pick
  import rv_mem_pkg::*;
#(
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned SW             = 3
) (
  input  logic          if_req,
  input  logic          lsu_req,
  input  logic [SW-1:0] streak,
  output owner_e        winner,
  output logic          grant_valid
);

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  // Winner defaults to LSU; fetch takes over when alone or when the LSU streak is spent.
  always_comb begin
    winner      = OWN_LSU;
    grant_valid = if_req | lsu_req;
    if (if_req && (!lsu_req || (streak == STREAK_MAX))) begin
      winner = OWN_IF;
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// the LSU, one transaction in flight at a time.
//
// state | meaning
// IDLE  | no transaction; arbitrate and grant in the same cycle
// ISSUE | mem_req held with the latched payload until mem_ready
// WAIT  | request accepted; waiting for mem_rvalid or the timeout
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_err,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_be,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            lsu_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned SW = cnt_w(MAX_LSU_STREAK);
  localparam int unsigned TW = cnt_w(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);
  // Last WAIT count before the timeout fires: TIMEOUT full WAIT cycles elapse.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  mem_req_t      pay_q, pay_d;

  logic          if_rvalid_q, if_rvalid_d;
  logic          lsu_rvalid_q, lsu_rvalid_d;
  logic          if_err_q, if_err_d;
  logic          lsu_err_q, lsu_err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] lsu_rdata_q, lsu_rdata_d;

  owner_e        pick_winner;
  logic          pick_valid;
  logic          rsp_fire;
  logic          rsp_err;
  logic          rsp_busy;

  rv_mem_arb_pick #(
    .MAX_LSU_STREAK(MAX_LSU_STREAK),
    .SW            (SW)
  ) u_pick (
    .if_req     (if_req),
    .lsu_req    (lsu_req),
    .streak     (streak_q),
    .winner     (pick_winner),
    .grant_valid(pick_valid)
  );

  // A response is being delivered this cycle; the next grant waits one cycle
  // so back-to-back transactions are spaced four cycles apart.
  assign rsp_busy = if_rvalid_q | lsu_rvalid_q;

  // Next-state, grant, streak and timeout logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    tmo_d    = tmo_q;
    pay_d    = pay_q;
    if_gnt   = 1'b0;
    lsu_gnt  = 1'b0;
    mem_req  = 1'b0;
    rsp_fire = 1'b0;
    rsp_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid && !rsp_busy && !rst) begin
          owner_d = pick_winner;
          state_d = ISSUE;
          if (pick_winner == OWN_LSU) begin
            lsu_gnt = 1'b1;
            pay_d   = '{we: lsu_we, addr: lsu_addr, wdata: lsu_wdata, be: lsu_be};
            if (if_req) begin
              streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
            end else begin
              streak_d = '0;
            end
          end else begin
            if_gnt   = 1'b1;
            pay_d    = '{we: 1'b0, addr: if_addr, wdata: '0, be: '1};
            streak_d = '0;
          end
        end
      end
      ISSUE: begin
        mem_req = !rst;
        if (mem_ready) begin
          state_d = WAIT;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A real response wins over a timeout landing in the same cycle.
        if (mem_rvalid) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Steer the response to the owner; the other port keeps its last rdata.
  always_comb begin
    if_rvalid_d  = 1'b0;
    lsu_rvalid_d = 1'b0;
    if_err_d     = 1'b0;
    lsu_err_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    if (rsp_fire) begin
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_err_d    = rsp_err;
        if_rdata_d  = rsp_err ? '0 : mem_rdata;
      end else begin
        lsu_rvalid_d = 1'b1;
        lsu_err_d    = rsp_err;
        lsu_rdata_d  = rsp_err ? '0 : mem_rdata;
      end
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      streak_q     <= '0;
      tmo_q        <= '0;
      pay_q        <= '0;
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      if_err_q     <= 1'b0;
      lsu_err_q    <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      tmo_q        <= tmo_d;
      pay_q        <= pay_d;
      if_rvalid_q  <= if_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      if_err_q     <= if_err_d;
      lsu_err_q    <= lsu_err_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign if_err     = if_err_q;
  assign if_rdata   = if_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_err    = lsu_err_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign mem_we     = pay_q.we;
  assign mem_addr   = pay_q.addr;
  assign mem_wdata  = pay_q.wdata;
  assign mem_be     = pay_q.be;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: a table of single transactions plus
// hand-written sequences for priority, starvation, and reset corner cases.
`timescale 1ns/1ps
module tb_rv_mem_arbiter;
  import rv_mem_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt, if_rvalid, if_err;
  logic [DW-1:0]   if_rdata;
  logic            lsu_req, lsu_we;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata;
  logic [DW/8-1:0] lsu_be;
  logic            lsu_gnt, lsu_rvalid, lsu_err;
  logic [DW-1:0]   lsu_rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ready, mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.AW(AW), .DW(DW), .MAX_LSU_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_be(lsu_be), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  logic       pk_if, pk_lsu, pk_valid;
  logic [2:0] pk_streak;
  owner_e     pk_winner;

  rv_mem_arb_pick #(.MAX_LSU_STREAK(MAXS), .SW(3)) u_pick (
    .if_req(pk_if), .lsu_req(pk_lsu), .streak(pk_streak),
    .winner(pk_winner), .grant_valid(pk_valid)
  );

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] last_if, last_lsu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({if_gnt, if_rvalid, if_err, lsu_gnt, lsu_rvalid, lsu_err, mem_req, mem_we}), 64'd0);
    chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    chk({tag, "_lsu_rdata"}, 64'(lsu_rdata), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_mem_be"}, 64'(mem_be), 64'd0);
  endtask

  typedef struct {
    logic        is_lsu;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mrdata;
    int          rdy_dly;
    int          rv_k;       // WAIT-cycle index carrying mem_rvalid, -1 = never
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_lat;    // WAIT-cycle index at which the requester rvalid is seen
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    if (v.is_lsu) begin
      lsu_req = 1'b1; lsu_we = v.we; lsu_addr = v.addr; lsu_wdata = v.wdata; lsu_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      lsu_we = 1'b1; lsu_wdata = 32'hFFFF_FFFF; lsu_be = 4'h0; lsu_addr = 32'hFFFF_0000;
    end
    settle();
    chk({tag, "_gnt"}, 64'(v.is_lsu ? lsu_gnt : if_gnt), 64'd1);
    chk({tag, "_gnt_other"}, 64'(v.is_lsu ? if_gnt : lsu_gnt), 64'd0);
    chk({tag, "_memreq_gntcyc"}, 64'(mem_req), 64'd0);
    nxt();
    if_req = 1'b0; lsu_req = 1'b0;
    if_addr = ~v.addr; lsu_addr = ~v.addr; lsu_wdata = ~v.wdata; lsu_be = ~v.be; lsu_we = ~v.we;
    for (int i = 0; i <= v.rdy_dly; i++) begin
      mem_ready = (i == v.rdy_dly);
      settle();
      chk({tag, "_mem_req"}, 64'(mem_req), 64'd1);
      chk({tag, "_mem_payload"}, {mem_we, mem_be, mem_wdata}, {v.exp_we, v.exp_be, v.exp_wdata});
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(v.addr));
      nxt();
    end
    mem_ready = 1'b0;
    for (int n = 0; n <= v.exp_lat; n++) begin
      mem_rvalid = (n == v.rv_k);
      mem_rdata  = (n == v.rv_k) ? v.mrdata : 32'h5A5A_5A5A;
      settle();
      chk({tag, "_wait_memreq"}, 64'(mem_req), 64'd0);
      if (n < v.exp_lat) begin
        chk({tag, "_early_rvalid"}, 64'({if_rvalid, lsu_rvalid}), 64'd0);
      end else begin
        chk({tag, "_rvalid"}, 64'({if_rvalid, lsu_rvalid}), v.is_lsu ? 64'd1 : 64'd2);
        chk({tag, "_rdata"}, 64'(v.is_lsu ? lsu_rdata : if_rdata), 64'(v.exp_rdata));
        chk({tag, "_err"}, 64'(v.is_lsu ? lsu_err : if_err), 64'(v.exp_err));
        chk({tag, "_other_rdata_hold"}, 64'(v.is_lsu ? if_rdata : lsu_rdata),
            64'(v.is_lsu ? last_if : last_lsu));
      end
      nxt();
    end
    mem_rvalid = 1'b0;
    settle();
    chk({tag, "_single_pulse"}, 64'({if_rvalid, lsu_rvalid}), 64'd0);
    if (v.is_lsu) last_lsu = v.exp_rdata;
    else          last_if  = v.exp_rdata;
  endtask

  typedef struct {
    logic       ir;
    logic       lr;
    logic [2:0] st;
    logic       ev;
    owner_e     ew;
  } pick_t;

  vec_t  vecs[6];
  pick_t picks[8];
  int    gseq[10];
  int    gexp[10];
  int    ng;

  initial begin
    //          lsu   we    addr          wdata         be    mrdata        rdy rvk  ewe   ebe   ewdata        lat erdata        eerr
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 32'hDEAD_BEEF, 0,  1,  1'b0, 4'hF, 32'h0,        2,  32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 32'h0,        0,  0,  1'b1, 4'h3, 32'h1234_5678, 1,  32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,        4'hF, 32'hCAFE_F00D, 5,  3,  1'b0, 4'hF, 32'h0,        4,  32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,        4'hC, 32'h99,        1,  -1, 1'b0, 4'hC, 32'h0,        8,  32'h0,        1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 32'h0BAD_C0DE, 2,  0,  1'b0, 4'hF, 32'h0,        1,  32'h0BAD_C0DE, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0308, 32'hA5A5_A5A5, 4'hF, 32'h1111_2222, 0,  7,  1'b1, 4'hF, 32'hA5A5_A5A5, 8,  32'h1111_2222, 1'b0};

    picks[0] = '{1'b0, 1'b0, 3'd0, 1'b0, OWN_LSU};
    picks[1] = '{1'b1, 1'b0, 3'd0, 1'b1, OWN_IF};
    picks[2] = '{1'b0, 1'b1, 3'd0, 1'b1, OWN_LSU};
    picks[3] = '{1'b1, 1'b1, 3'd0, 1'b1, OWN_LSU};
    picks[4] = '{1'b1, 1'b1, 3'd3, 1'b1, OWN_LSU};
    picks[5] = '{1'b1, 1'b1, 3'd4, 1'b1, OWN_IF};
    picks[6] = '{1'b0, 1'b1, 3'd4, 1'b1, OWN_LSU};
    picks[7] = '{1'b1, 1'b0, 3'd4, 1'b1, OWN_IF};

    gexp = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    pk_if = 1'b0; pk_lsu = 1'b0; pk_streak = '0;
    last_if = '0; last_lsu = '0;
    nxt(); nxt(); nxt();
    rst = 1'b0;
    settle();
    chk_all_zero("reset");

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous requests: LSU first, fetch granted only after the LSU rvalid.
    nxt();
    if_req = 1'b1; if_addr = 32'h400;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h200; lsu_wdata = 32'h1234_5678; lsu_be = 4'h3;
    settle();
    chk("sim_gnt", 64'({lsu_gnt, if_gnt}), 64'd2);
    nxt();
    lsu_req = 1'b0; mem_ready = 1'b1;
    settle();
    chk("sim_mem_store", {mem_req, mem_we, mem_be, mem_wdata}, {1'b1, 1'b1, 4'h3, 32'h1234_5678});
    chk("sim_mem_addr", 64'(mem_addr), 64'h200);
    chk("sim_no_if_gnt_issue", 64'(if_gnt), 64'd0);
    nxt();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
    settle();
    chk("sim_no_if_gnt_wait", 64'(if_gnt), 64'd0);
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    settle();
    chk("sim_lsu_rvalid", 64'({lsu_rvalid, if_gnt}), 64'd2);
    chk("sim_lsu_rdata", 64'(lsu_rdata), 64'h1234);
    nxt();
    settle();
    chk("sim_if_gnt_after", 64'({if_gnt, lsu_gnt}), 64'd2);
    nxt();
    if_req = 1'b0; mem_ready = 1'b1;
    settle();
    chk("sim_if_mem", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h400});
    nxt();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    nxt();
    mem_rvalid = 1'b0;
    settle();
    chk("sim_if_rvalid", 64'({if_rvalid, if_rdata}), {31'd0, 1'b1, 32'h77});
    nxt();

    // Reset while in WAIT, then a stale mem_rvalid after reset.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h500; lsu_be = 4'hF;
    settle();
    chk("rstw_gnt", 64'(lsu_gnt), 64'd1);
    nxt();
    lsu_req = 1'b0; mem_ready = 1'b1;
    nxt();
    mem_ready = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    settle();
    chk_all_zero("rstw");
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    nxt();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rstw_no_rvalid", 64'({if_rvalid, lsu_rvalid, if_rdata, lsu_rdata}), 64'd0);
      nxt();
    end
    last_if = '0; last_lsu = '0;
    run_txn(vecs[0], "post_rst");

    // Both requesters held: LSU x4, IF, LSU x4, IF with a zero-wait memory.
    nxt();
    if_req = 1'b1; if_addr = 32'h600;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h700; lsu_be = 4'hF;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = '0;
    ng = 0;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      settle();
      if (lsu_gnt || if_gnt) begin
        gseq[ng] = (lsu_gnt && if_gnt) ? 2 : (lsu_gnt ? 1 : 0);
        ng++;
      end
      nxt();
    end
    chk("starve_grant_count", 64'(ng), 64'd10);
    if_req = 1'b0; lsu_req = 1'b0;
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("starve_grant%0d", i), 64'(gseq[i]), 64'(gexp[i]));
    end
    for (int i = 0; i < 4; i++) nxt();
    mem_ready = 1'b0; mem_rvalid = 1'b0;

    // Pick logic in isolation.
    for (int i = 0; i < 8; i++) begin
      pk_if = picks[i].ir; pk_lsu = picks[i].lr; pk_streak = picks[i].st;
      settle();
      chk($sformatf("pick%0d_valid", i), 64'(pk_valid), 64'(picks[i].ev));
      if (picks[i].ev) chk($sformatf("pick%0d_winner", i), 64'(pk_winner), 64'(picks[i].ew));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
